// File: rtl/tmr_mod_counter.sv
// Triple-modular-redundant up/down modulo counter with scrubbing, per-replica health tracking, error pulses.
// Latency: q_out is combinational majority of replicas (0 cycles); err/load_err flags are registered (1 cycle).
// Backpressure: none, a step is taken on every enabled clock; optional macro TMR_CORR_CNT_EN adds corr_cnt.
module tmr_mod_counter #(
    parameter int              WIDTH      = 8,
    parameter longint unsigned MODULO     = 0,
    parameter int              FAIL_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_out,
    output logic             err_corr,
    output logic             err_uncorr,
    output logic             load_err,
    output logic [2:0]       rep_failed
`ifdef TMR_CORR_CNT_EN
    ,
    output logic [15:0]      corr_cnt
`endif
);

    // MODULO == 0 means the full 2^WIDTH range, so the top value is all ones.
    localparam logic [WIDTH-1:0] MAXV  = (MODULO == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULO - 64'd1);
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]       LIMIT = 8'(FAIL_LIMIT);

    typedef enum logic {
        ST_OK     = 1'b0,
        ST_FAILED = 1'b1
    } health_t;

    logic [WIDTH-1:0] r_rep0;
    logic [WIDTH-1:0] r_rep1;
    logic [WIDTH-1:0] r_rep2;
    logic             r_err_corr;
    logic             r_err_uncorr;
    logic             r_load_err;

    logic [WIDTH-1:0] w_voted;
    logic [WIDTH-1:0] w_next;
    logic             w_load_ok;
    logic [2:0]       w_mis;
    logic             w_corr_det;
    logic             w_uncorr_det;

    always_comb begin
        w_voted      = (r_rep0 & r_rep1) | (r_rep0 & r_rep2) | (r_rep1 & r_rep2);
        w_load_ok    = (load_val <= MAXV);
        w_mis        = {(r_rep2 != w_voted), (r_rep1 != w_voted), (r_rep0 != w_voted)};
        w_corr_det   = (w_mis == 3'b001) || (w_mis == 3'b010) || (w_mis == 3'b100);
        w_uncorr_det = (r_rep0 != r_rep1) && (r_rep0 != r_rep2) && (r_rep1 != r_rep2);
    end

    // Every replica is rebuilt from the vote, never from itself, so one upset lasts one cycle.
    always_comb begin
        w_next = w_voted;
        if (load) begin
            w_next = w_load_ok ? load_val : '0;
        end else if (enable) begin
            if (up_dn) begin
                w_next = (w_voted == MAXV) ? '0 : (w_voted + ONE);
            end else begin
                w_next = (w_voted == '0) ? MAXV : (w_voted - ONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rep0       <= '0;
            r_rep1       <= '0;
            r_rep2       <= '0;
            r_err_corr   <= 1'b0;
            r_err_uncorr <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_rep0       <= w_next;
            r_rep1       <= w_next;
            r_rep2       <= w_next;
            r_err_corr   <= w_corr_det;
            r_err_uncorr <= w_uncorr_det;
            r_load_err   <= load && !w_load_ok;
        end
    end

    assign q_out      = w_voted;
    assign err_corr   = r_err_corr;
    assign err_uncorr = r_err_uncorr;
    assign load_err   = r_load_err;

    // Health tracking is report-only; it never feeds back into the vote.
    for (genvar gi = 0; gi < 3; gi++) begin : g_health
        health_t    r_state;
        health_t    w_state_nxt;
        logic [7:0] r_run;
        logic [7:0] w_run_nxt;
        logic       w_failed;

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_state <= ST_OK;
                r_run   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_run   <= w_run_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_run_nxt   = r_run;
            case (r_state)
                ST_OK: begin
                    if (w_mis[gi]) begin
                        if (r_run == (LIMIT - 8'd1)) begin
                            w_state_nxt = ST_FAILED;
                            w_run_nxt   = LIMIT;
                        end else begin
                            w_run_nxt = r_run + 8'd1;
                        end
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                ST_FAILED: begin
                    w_state_nxt = ST_FAILED;
                end
                default: begin
                    w_state_nxt = ST_OK;
                end
            endcase
        end

        always_comb begin
            w_failed = (r_state == ST_FAILED);
        end

        assign rep_failed[gi] = w_failed;
    end

`ifdef TMR_CORR_CNT_EN
    logic [15:0] r_corr_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_corr_cnt <= '0;
        end else if (w_corr_det && (r_corr_cnt != 16'hFFFF)) begin
            r_corr_cnt <= r_corr_cnt + 16'd1;
        end
    end

    assign corr_cnt = r_corr_cnt;
`endif

endmodule

// File: tb/tb_tmr_mod_counter.sv
// Bench for tmr_mod_counter (WIDTH=8, MODULO=10, FAIL_LIMIT=4): directed scenarios plus random
// stimulus against a modular-arithmetic reference model; faults planted with force/release.
module tb_tmr_mod_counter;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       up_dn;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] q_out;
    logic       err_corr;
    logic       err_uncorr;
    logic       load_err;
    logic [2:0] rep_failed;
`ifdef TMR_CORR_CNT_EN
    logic [15:0] corr_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_q = 0;

    tmr_mod_counter #(
        .WIDTH(8),
        .MODULO(10),
        .FAIL_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .up_dn(up_dn),
        .load(load),
        .load_val(load_val),
        .q_out(q_out),
        .err_corr(err_corr),
        .err_uncorr(err_uncorr),
        .load_err(load_err),
        .rep_failed(rep_failed)
`ifdef TMR_CORR_CNT_EN
        ,
        .corr_cnt(corr_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain modular arithmetic on integers.
    function automatic int model_next(int q, bit ld, int lv, bit en, bit up);
        if (ld) return (lv < M) ? lv : 0;
        if (en) return up ? (q + 1) % M : (q + M - 1) % M;
        return q;
    endfunction

    task automatic test_reset;
        rst = 1'b0; enable = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 8'd7;
        tick();
        tick();
        exp_q = 0;
        n_cmp++; if (q_out !== 8'd0) begin n_err++; $display("FAIL reset_q: got %0d want 0", q_out); end
        n_cmp++; if ({err_corr, err_uncorr, load_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {err_corr, err_uncorr, load_err}); end
        n_cmp++; if (rep_failed !== 3'b000) begin n_err++; $display("FAIL reset_rep_failed: got %b want 000", rep_failed); end
`ifdef TMR_CORR_CNT_EN
        n_cmp++; if (corr_cnt !== 16'd0) begin n_err++; $display("FAIL reset_corr_cnt: got %0d want 0", corr_cnt); end
`endif
        rst = 1'b1; enable = 1'b0; load = 1'b0; load_val = 8'd0;
    endtask

    task automatic test_count_up;
        int seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        enable = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_q = seq[i];
            n_cmp++; if (q_out !== 8'(exp_q)) begin n_err++; $display("FAIL count_up[%0d]: got %0d want %0d", i, q_out, exp_q); end
            n_cmp++; if ({err_corr, err_uncorr, load_err} !== 3'b000) begin n_err++; $display("FAIL count_up_flags[%0d]: got %b want 000", i, {err_corr, err_uncorr, load_err}); end
        end
        enable = 1'b0;
    endtask

    task automatic test_load_count_down;
        int seq [5] = '{2, 1, 0, 9, 8};
        load = 1'b1; load_val = 8'd3;
        tick();
        exp_q = 3;
        n_cmp++; if (q_out !== 8'd3) begin n_err++; $display("FAIL load3: got %0d want 3", q_out); end
        n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL load3_err: got %b want 0", load_err); end
        load = 1'b0; enable = 1'b1; up_dn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_q = seq[i];
            n_cmp++; if (q_out !== 8'(exp_q)) begin n_err++; $display("FAIL count_down[%0d]: got %0d want %0d", i, q_out, exp_q); end
        end
        enable = 1'b0;
        load = 1'b1; load_val = 8'd9;
        tick();
        exp_q = 9;
        n_cmp++; if ({q_out, load_err} !== {8'd9, 1'b0}) begin n_err++; $display("FAIL load_max: got %0d/%b want 9/0", q_out, load_err); end
        load_val = 8'd12;
        tick();
        exp_q = 0;
        n_cmp++; if (q_out !== 8'd0) begin n_err++; $display("FAIL load_bad_q: got %0d want 0", q_out); end
        n_cmp++; if (load_err !== 1'b1) begin n_err++; $display("FAIL load_bad_err: got %b want 1", load_err); end
        load = 1'b0;
        tick();
        n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL load_err_pulse: got %b want 0", load_err); end
    endtask

    task automatic test_random;
        bit ld, en, up;
        int lv;
        for (int i = 0; i < 300; i++) begin
            ld = ($urandom_range(0, 7) == 0);
            en = $urandom_range(0, 1) == 1;
            up = $urandom_range(0, 1) == 1;
            lv = $urandom_range(0, 15);
            load = ld; enable = en; up_dn = up; load_val = 8'(lv);
            tick();
            exp_q = model_next(exp_q, ld, lv, en, up);
            n_cmp++; if (q_out !== 8'(exp_q)) begin n_err++; $display("FAIL random_q[%0d]: got %0d want %0d", i, q_out, exp_q); end
            n_cmp++; if (load_err !== (ld && lv >= M)) begin n_err++; $display("FAIL random_load_err[%0d]: got %b want %b", i, load_err, (ld && lv >= M)); end
            n_cmp++; if ({err_corr, err_uncorr} !== 2'b00) begin n_err++; $display("FAIL random_err[%0d]: got %b want 00", i, {err_corr, err_uncorr}); end
        end
        load = 1'b0; enable = 1'b0;
    endtask

    task automatic test_single_upset;
        enable = 1'b0; load = 1'b0;
        force dut.r_rep0 = 8'h20; force dut.r_rep1 = 8'h20; force dut.r_rep2 = 8'h20;
        #1;
        release dut.r_rep0; release dut.r_rep1; release dut.r_rep2;
        tick();
        n_cmp++; if ({q_out, err_corr} !== {8'h20, 1'b0}) begin n_err++; $display("FAIL upset_pre: got %h/%b want 20/0", q_out, err_corr); end
        force dut.r_rep1 = 8'h55;
        #1;
        release dut.r_rep1;
        #1;
        n_cmp++; if (q_out !== 8'h20) begin n_err++; $display("FAIL upset_vote: got %h want 20", q_out); end
        tick();
        n_cmp++; if (err_corr !== 1'b1) begin n_err++; $display("FAIL upset_err_corr: got %b want 1", err_corr); end
        n_cmp++; if (dut.r_rep1 !== 8'h20) begin n_err++; $display("FAIL upset_scrub: got %h want 20", dut.r_rep1); end
        n_cmp++; if (err_uncorr !== 1'b0) begin n_err++; $display("FAIL upset_uncorr: got %b want 0", err_uncorr); end
`ifdef TMR_CORR_CNT_EN
        n_cmp++; if (corr_cnt !== 16'd1) begin n_err++; $display("FAIL upset_corr_cnt: got %0d want 1", corr_cnt); end
`endif
        tick();
        n_cmp++; if (err_corr !== 1'b0) begin n_err++; $display("FAIL upset_pulse: got %b want 0", err_corr); end
    endtask

    task automatic test_stuck_replica;
        force dut.r_rep2 = 8'h7F;
        tick(); tick(); tick();
        n_cmp++; if (rep_failed !== 3'b000) begin n_err++; $display("FAIL stuck_3cyc: got %b want 000", rep_failed); end
        tick();
        n_cmp++; if (rep_failed !== 3'b100) begin n_err++; $display("FAIL stuck_4cyc: got %b want 100", rep_failed); end
        n_cmp++; if ({q_out, err_corr} !== {8'h20, 1'b1}) begin n_err++; $display("FAIL stuck_vote: got %h/%b want 20/1", q_out, err_corr); end
        release dut.r_rep2;
        tick(); tick(); tick();
        n_cmp++; if (rep_failed !== 3'b100) begin n_err++; $display("FAIL stuck_sticky: got %b want 100", rep_failed); end
        n_cmp++; if (dut.r_rep2 !== 8'h20) begin n_err++; $display("FAIL stuck_scrub: got %h want 20", dut.r_rep2); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_q = 0;
        n_cmp++; if ({rep_failed, q_out} !== {3'b000, 8'd0}) begin n_err++; $display("FAIL stuck_reset: got %b/%h want 000/00", rep_failed, q_out); end
    endtask

    task automatic test_uncorrectable;
        force dut.r_rep0 = 8'h01; force dut.r_rep1 = 8'h02; force dut.r_rep2 = 8'h04;
        #1;
        release dut.r_rep0; release dut.r_rep1; release dut.r_rep2;
        #1;
        n_cmp++; if (q_out !== 8'h00) begin n_err++; $display("FAIL uncorr_vote: got %h want 00", q_out); end
        enable = 1'b1; up_dn = 1'b1;
        tick();
        enable = 1'b0;
        n_cmp++; if ({err_uncorr, err_corr} !== 2'b10) begin n_err++; $display("FAIL uncorr_flags: got %b want 10", {err_uncorr, err_corr}); end
        n_cmp++; if ({dut.r_rep0, dut.r_rep1, dut.r_rep2} !== {8'h01, 8'h01, 8'h01}) begin n_err++; $display("FAIL uncorr_next: got %h %h %h want 01 01 01", dut.r_rep0, dut.r_rep1, dut.r_rep2); end
        tick();
        exp_q = 1;
        n_cmp++; if ({err_uncorr, q_out} !== {1'b0, 8'h01}) begin n_err++; $display("FAIL uncorr_pulse: got %b/%h want 0/01", err_uncorr, q_out); end
    endtask

    task automatic test_load_enable_reset;
        load = 1'b1; enable = 1'b1; up_dn = 1'b1; load_val = 8'd5;
        tick();
        exp_q = model_next(exp_q, 1'b1, 5, 1'b1, 1'b1);
        n_cmp++; if (q_out !== 8'(exp_q)) begin n_err++; $display("FAIL load_wins: got %0d want %0d", q_out, exp_q); end
        load = 1'b0;
        tick(); tick();
        exp_q = 7;
        n_cmp++; if (q_out !== 8'(exp_q)) begin n_err++; $display("FAIL pre_reset_count: got %0d want %0d", q_out, exp_q); end
        rst = 1'b0; load = 1'b1; load_val = 8'd12;
        tick();
        n_cmp++; if ({q_out, err_corr, err_uncorr, load_err, rep_failed} !== 14'd0) begin n_err++; $display("FAIL midcount_reset: got %h/%b%b%b/%b want all 0", q_out, err_corr, err_uncorr, load_err, rep_failed); end
        rst = 1'b1; load = 1'b0; enable = 1'b0;
        tick();
        n_cmp++; if (q_out !== 8'd0) begin n_err++; $display("FAIL post_reset_hold: got %0d want 0", q_out); end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'd0;
        test_reset();
        test_count_up();
        test_load_count_down();
        test_random();
        test_single_upset();
        test_stuck_replica();
        test_uncorrectable();
        test_load_enable_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
